reg_file_mp: RTL

Parametrised multi-port register file for the MIPS datapath, the next-generation replacement for the single-write / dual-read register file. It provides NUM_RD combinational read ports, NUM_WR prioritised write ports, write-to-read bypass, a hardwired zero register, asynchronous clearing of all registers, and a per-register busy scoreboard used by decode for hazard detection. It sits between decode (reads, reservations) and writeback (writes, busy clear).

---
 rtl/reg_file_mp.sv | 109 ++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp -- multi-port register file for the MIPS datapath.
//
// Provides NUM_RD combinational read ports with write-to-read bypass,
// NUM_WR write ports (higher port index wins on address collision),
// a hardwired zero register, asynchronous clearing of all state, and a
// per-register busy scoreboard used by decode for hazard detection.
//
// Ports:
//   CLK    in   clock, all state updates on the rising edge
//   RST_n  in   asynchronous active-low reset (clears registers and busy bits)
//   WE     in   per-port write enable                    [NUM_WR]
//   WA     in   write addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   WD     in   write data,      port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   RA     in   read addresses,  port j at [j*ADDR_WIDTH +: ADDR_WIDTH]
//   RD     out  read data,       port j at [j*DATA_WIDTH +: DATA_WIDTH]
//   RSV    in   reserve request, marks RSV_A busy at the edge
//   RSV_A  in   register to reserve
//   BUSY   out  busy status of register RA[j]           [NUM_RD]
//   TAP    out  stored value of register TAP_IDX (storage only, no bypass)
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int TAP_IDX    = 16
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic [NUM_WR-1:0]          WE,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] WA,
    input  logic [NUM_WR*DATA_WIDTH-1:0] WD,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] RA,
    output logic [NUM_RD*DATA_WIDTH-1:0] RD,
    input  logic                       RSV,
    input  logic [ADDR_WIDTH-1:0]      RSV_A,
    output logic [NUM_RD-1:0]          BUSY,
    output logic [DATA_WIDTH-1:0]      TAP
);

    localparam logic [ADDR_WIDTH-1:0] TAP_A = ADDR_WIDTH'(TAP_IDX);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    // Next state. Ports are applied in ascending order so the highest
    // enabled port wins a collision. Writes clear busy; a reservation is
    // applied last so a new producer supersedes a completing one.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (WE[k] && (WA[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                regs_d[WA[k*ADDR_WIDTH +: ADDR_WIDTH]] = WD[k*DATA_WIDTH +: DATA_WIDTH];
                busy_d[WA[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (RSV && (RSV_A != '0)) begin
            busy_d[RSV_A] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Read ports: zero register first, then bypass from the highest
    // matching write port, then storage. A pending write to the address
    // hides its busy bit because the value is already on the bypass path.
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  hit;

        assign ra = RA[j*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rdata = regs_q[ra];
            hit   = 1'b0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (WE[k] && (WA[k*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                    rdata = WD[k*DATA_WIDTH +: DATA_WIDTH];
                    hit   = 1'b1;
                end
            end
            if (ra == '0) begin
                rdata = '0;
            end
        end

        assign RD[j*DATA_WIDTH +: DATA_WIDTH] = rdata;
        assign BUSY[j] = (ra != '0) && !hit && busy_q[ra];
    end

    assign TAP = regs_q[TAP_A];

endmodule
